// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one data-memory port between the CPU MEM stage and an external requester
// Optional macro DMEM_ARB_STATS_EN adds saturating stall-cycle and ext-grant counters.
module dmem_port_arbiter #(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              cpu_req,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ext_req,
   input  logic              ext_wen,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   input  logic              ext_lock,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]       stat_stall_cnt,
   output logic [31:0]       stat_ext_cnt
`endif
);

   localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [0:0] {
      S_CPU      = 1'b0,
      S_EXT_LOCK = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   starve_cnt;
   logic               cpu_ok;
   logic               starve_full;
   logic               cpu_granted;
   logic               ext_granted;
   logic               rd_valid_q;
   logic               rd_ext_q;

   assign cpu_ok      = enable & cpu_req;
   assign starve_full = ext_req & (starve_cnt == STARVE_LIM);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_CPU;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: a locked ext grant holds the port until the lock or the request drops
   always_comb begin
      state_nxt = state;
      case (state)
         S_CPU: begin
            if (ext_granted && ext_lock) begin
               state_nxt = S_EXT_LOCK;
            end
         end
         S_EXT_LOCK: begin
            if (!ext_lock || !ext_req) begin
               state_nxt = S_CPU;
            end
         end
         default: state_nxt = S_CPU;
      endcase
   end

   // Grant decode; nothing is issued while reset is held
   always_comb begin
      cpu_granted = 1'b0;
      ext_granted = 1'b0;
      if (!rst) begin
         case (state)
            S_CPU: begin
               cpu_granted = cpu_ok & ~starve_full;
               ext_granted = ext_req & ~cpu_granted;
            end
            S_EXT_LOCK: begin
               ext_granted = ext_req;
               cpu_granted = cpu_ok & ~ext_req;
            end
            default: begin
               cpu_granted = 1'b0;
               ext_granted = 1'b0;
            end
         endcase
      end
   end

   // Port issue and requester-facing outputs
   always_comb begin
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_wen    = 1'b0;
      mem_ren    = 1'b0;
      if (ext_granted) begin
         mem_addr  = ext_addr;
         mem_wdata = ext_wdata;
         mem_wen   = ext_wen;
         mem_ren   = ~ext_wen;
      end else if (cpu_granted) begin
         mem_wen   = cpu_wen;
         mem_ren   = ~cpu_wen;
      end
      cpu_stall  = ~rst & cpu_ok & ~cpu_granted;
      ext_gnt    = ext_granted;
      cpu_rvalid = ~rst & rd_valid_q & ~rd_ext_q;
      ext_rvalid = ~rst & rd_valid_q & rd_ext_q;
      cpu_rdata  = mem_rdata;
      ext_rdata  = mem_rdata;
   end

   // Counts CPU wins over a waiting ext requester
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (ext_granted || !ext_req) begin
         starve_cnt <= '0;
      end else if (cpu_granted && (starve_cnt != STARVE_LIM)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Read owner tracking for the one-cycle memory latency
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_ext_q   <= 1'b0;
      end else begin
         rd_valid_q <= mem_ren;
         rd_ext_q   <= ext_granted;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_cnt <= '0;
         stat_ext_cnt   <= '0;
      end else begin
         if (cpu_stall && (stat_stall_cnt != 32'hFFFF_FFFF)) begin
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
         end
         if (ext_granted && (stat_ext_cnt != 32'hFFFF_FFFF)) begin
            stat_ext_cnt <= stat_ext_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
// Directed scenarios plus randomized traffic against a request-level reference model.
module tb_dmem_port_arbiter;

   localparam int SMAX = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_wen = 1'b0;
   logic [63:0] cpu_addr = '0;
   logic [63:0] cpu_wdata = '0;
   logic        cpu_stall;
   logic        cpu_rvalid;
   logic [63:0] cpu_rdata;
   logic        ext_req = 1'b0;
   logic        ext_wen = 1'b0;
   logic [63:0] ext_addr = '0;
   logic [63:0] ext_wdata = '0;
   logic        ext_lock = 1'b0;
   logic        ext_gnt;
   logic        ext_rvalid;
   logic [63:0] ext_rdata;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic        mem_ren;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stat_stall_cnt;
   logic [31:0] stat_ext_cnt;
`endif

   dmem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ext_req(ext_req), .ext_wen(ext_wen), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      , .stat_stall_cnt(stat_stall_cnt), .stat_ext_cnt(stat_ext_cnt)
`endif
   );

   always #5 clk = ~clk;

   // One-cycle-latency SRAM behind the port
   logic [63:0] sram [256];
   always @(posedge clk) begin
      if (mem_wen) sram[mem_addr[7:0]] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr[7:0]];
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model state
   int          m_wait = 0;
   bit          m_burst = 0;
   bit          p_cpu_rv = 0, p_ext_rv = 0, p_known = 0;
   logic [63:0] p_rdata = '0;
   logic [63:0] ref_mem [256];
   bit          written [256];
   longint      m_stall_cnt = 0, m_ext_cnt = 0;

   // Observations of the most recent cycle, for directed checks
   logic        o_stall, o_gnt, o_crv, o_erv, o_mren, o_mwen;
   logic [63:0] o_crd, o_erd;

   task automatic step(input logic r, en, cr, cw, input logic [63:0] ca, cd,
                       input logic er, ew, input logic [63:0] ea, ed, input logic el);
      bit cpu_win, ext_win, e_stall, wr;
      logic [7:0] idx;
      @(negedge clk);
      rst = r; enable = en;
      cpu_req = cr; cpu_wen = cw; cpu_addr = ca; cpu_wdata = cd;
      ext_req = er; ext_wen = ew; ext_addr = ea; ext_wdata = ed; ext_lock = el;
      #1;
      check("cpu_rvalid", cpu_rvalid, r ? 1'b0 : p_cpu_rv);
      check("ext_rvalid", ext_rvalid, r ? 1'b0 : p_ext_rv);
      if (!r && p_known && p_cpu_rv) check("cpu_rdata", cpu_rdata, p_rdata);
      if (!r && p_known && p_ext_rv) check("ext_rdata", ext_rdata, p_rdata);
`ifdef DMEM_ARB_STATS_EN
      check("stat_stall", stat_stall_cnt, m_stall_cnt[31:0]);
      check("stat_ext", stat_ext_cnt, m_ext_cnt[31:0]);
`endif
      cpu_win = 0;
      ext_win = 0;
      if (!r) begin
         if (en && cr && (m_burst ? !er : !(er && m_wait == SMAX))) cpu_win = 1;
         else if (er) ext_win = 1;
      end
      e_stall = !r && en && cr && !cpu_win;
      check("cpu_stall", cpu_stall, e_stall);
      check("ext_gnt", ext_gnt, ext_win);
      check("mem_ren", mem_ren, (cpu_win && !cw) || (ext_win && !ew));
      check("mem_wen", mem_wen, (cpu_win && cw) || (ext_win && ew));
      if (cpu_win || ext_win) begin
         check("mem_addr", mem_addr, cpu_win ? ca : ea);
         if (cpu_win ? cw : ew) check("mem_wdata", mem_wdata, cpu_win ? cd : ed);
      end
      o_stall = cpu_stall; o_gnt = ext_gnt; o_crv = cpu_rvalid; o_erv = ext_rvalid;
      o_mren = mem_ren; o_mwen = mem_wen; o_crd = cpu_rdata; o_erd = ext_rdata;
      if (r) begin
         m_wait = 0; m_burst = 0; p_cpu_rv = 0; p_ext_rv = 0;
         m_stall_cnt = 0; m_ext_cnt = 0;
      end else begin
         p_cpu_rv = cpu_win && !cw;
         p_ext_rv = ext_win && !ew;
         if (cpu_win || ext_win) begin
            idx = cpu_win ? ca[7:0] : ea[7:0];
            wr  = cpu_win ? cw : ew;
            if (wr) begin
               ref_mem[idx] = cpu_win ? cd : ed;
               written[idx] = 1;
            end else begin
               p_rdata = ref_mem[idx];
               p_known = written[idx];
            end
         end
         if (ext_win || !er) m_wait = 0;
         else if (cpu_win && m_wait < SMAX) m_wait++;
         m_burst = m_burst ? (el && er) : (ext_win && el);
         if (e_stall) m_stall_cnt++;
         if (ext_win) m_ext_cnt++;
      end
   endtask

   task automatic idle(input logic r);
      step(r, 0, 0, 0, '0, '0, 0, 0, '0, '0, 0);
   endtask

   bit          h_stall, e_pend;
   logic        r_r, r_en, r_cr, r_cw, r_er, r_ew, r_el;
   logic [63:0] r_ca, r_cd, r_ea, r_ed;

   initial begin
      // Reset state
      idle(1);
      idle(0);
      check("rst_cpu_rvalid", o_crv, 1'b0);
      check("rst_ext_rvalid", o_erv, 1'b0);
      check("rst_ext_gnt", o_gnt, 1'b0);
      check("rst_mem_wen", o_mwen, 1'b0);
      check("rst_mem_ren", o_mren, 1'b0);

      // 1: CPU disabled, ext write then read back
      step(0, 0, 0, 0, '0, '0, 1, 1, 64'h40, 64'hDEAD, 0);
      check("s1_wr_gnt", o_gnt, 1'b1);
      check("s1_wr_stall", o_stall, 1'b0);
      step(0, 0, 0, 0, '0, '0, 1, 0, 64'h40, '0, 0);
      check("s1_rd_gnt", o_gnt, 1'b1);
      check("s1_wr_no_rvalid", o_erv, 1'b0);
      idle(0);
      check("s1_rvalid", o_erv, 1'b1);
      check("s1_rdata", o_erd, 64'hDEAD);

      // 2 (+6): CPU load each cycle, ext held; ext forced after SMAX CPU grants
      idle(1);
      for (int k = 0; k <= SMAX; k++) begin
         step(0, 1, 1, 0, 64'(8 * k), '0, 1, 0, 64'h10, '0, 0);
         check("s2_ext_gnt", o_gnt, k == SMAX);
         check("s2_stall", o_stall, k == SMAX);
      end
      step(0, 1, 1, 0, 64'h80, '0, 0, 0, '0, '0, 0);
      check("s2_ext_rvalid", o_erv, 1'b1);
      check("s2_cpu_after", o_mren & ~o_gnt, 1'b1);
`ifdef DMEM_ARB_STATS_EN
      idle(0);
      check("s6_stall_cnt", stat_stall_cnt, 32'd1);
      check("s6_ext_cnt", stat_ext_cnt, 32'd1);
`endif
      // starvation count cleared: CPU wins a fresh contention
      step(0, 1, 1, 0, 64'h88, '0, 1, 0, 64'h18, '0, 0);
      check("s2_cnt_clear", o_gnt, 1'b0);
      idle(0);

      // 3: simultaneous requests, CPU wins
      idle(1);
      step(0, 1, 1, 0, 64'h30, '0, 1, 0, 64'h38, '0, 0);
      check("s3_ext_gnt", o_gnt, 1'b0);
      check("s3_stall", o_stall, 1'b0);
      step(0, 1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
      check("s3_cpu_rvalid", o_crv, 1'b1);
      check("s3_ext_rvalid", o_erv, 1'b0);
      idle(0);
      check("s3_cpu_rvalid_once", o_crv, 1'b0);

      // 4: forced ext grant with lock, burst of 4 reads
      idle(1);
      for (int k = 0; k < SMAX + 4; k++) begin
         step(0, 1, 1, 0, 64'h60, '0, 1, 0, (k <= SMAX) ? 64'h20 : 64'(32 + 8 * (k - SMAX)), '0,
              k < SMAX + 3);
         if (k >= SMAX) begin
            check("s4_ext_gnt", o_gnt, 1'b1);
            check("s4_stall", o_stall, 1'b1);
         end
      end
      step(0, 1, 1, 0, 64'h60, '0, 0, 0, '0, '0, 0);
      check("s4_cpu_granted", o_mren & ~o_gnt & ~o_stall, 1'b1);
      idle(0);

      // 5: reset right after a CPU read issue
      idle(1);
      step(0, 1, 1, 0, 64'h48, '0, 0, 0, '0, '0, 0);
      step(1, 1, 1, 0, 64'h48, '0, 1, 1, 64'h50, 64'h1, 0);
      check("s5_cpu_rvalid", o_crv, 1'b0);
      check("s5_ext_gnt", o_gnt, 1'b0);
      check("s5_mem_ren", o_mren, 1'b0);
      check("s5_mem_wen", o_mwen, 1'b0);
      check("s5_stall", o_stall, 1'b0);
      idle(0);
      check("s5_cpu_rvalid_after", o_crv, 1'b0);

      // Randomized traffic honoring the hold-while-waiting rules
      h_stall = 0;
      e_pend = 0;
      r_cr = 0; r_cw = 0; r_ca = '0; r_cd = '0;
      r_er = 0; r_ew = 0; r_ea = '0; r_ed = '0; r_el = 0;
      for (int i = 0; i < 3000; i++) begin
         r_r  = ($urandom_range(0, 199) == 0);
         r_en = ($urandom_range(0, 7) != 0);
         if (!h_stall) begin
            r_cr = $urandom_range(0, 1);
            r_cw = $urandom_range(0, 1);
            r_ca = 64'($urandom_range(0, 255));
            r_cd = {$urandom, $urandom};
         end
         if (!e_pend) begin
            r_er = ($urandom_range(0, 2) == 0);
            r_ew = $urandom_range(0, 1);
            r_ea = 64'($urandom_range(0, 255));
            r_ed = {$urandom, $urandom};
            r_el = ($urandom_range(0, 3) == 0);
         end
         step(r_r, r_en, r_cr, r_cw, r_ca, r_cd, r_er, r_ew, r_ea, r_ed, r_el);
         h_stall = o_stall;
         e_pend  = r_er && !o_gnt;
      end
      idle(0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
